cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/dds_pkg.sv | 46 ++++
 rtl/cordic.sv | 77 +++++++
 rtl/cordic_sched.sv | 161 ++++++++++++++++
 tb/tb_cordic_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the two-channel DDS scheduler and its CORDIC core.
package dds_pkg;

    localparam int unsigned ITER_DEF = 10;
    localparam int unsigned NCH      = 2;

    function automatic int unsigned cordic_lat(input int unsigned iter);
        return iter + 2;
    endfunction

    localparam int unsigned LAT = cordic_lat(ITER_DEF);

    // 1/1.16443 in Q1.15: cancels the gain of a CORDIC whose rotations start at 2^-1
    localparam logic [15:0] AMP_DEFAULT = 16'h6DED;

    typedef logic ch_t;

    typedef struct packed {
        logic valid;
        ch_t  ch;
    } tag_t;

    // atan(2^-i) as a fraction of one turn, scaled by 2^32
    function automatic logic [31:0] atan_turns32(input int unsigned i);
        case (i)
            0:       return 32'h2000_0000;
            1:       return 32'h12E4_051E;
            2:       return 32'h09FB_385B;
            3:       return 32'h0511_11D4;
            4:       return 32'h028B_0D43;
            5:       return 32'h0145_D7E1;
            6:       return 32'h00A2_F61E;
            7:       return 32'h0051_7C55;
            8:       return 32'h0028_BE53;
            9:       return 32'h0014_5F2F;
            10:      return 32'h000A_2F98;
            11:      return 32'h0005_17CC;
            12:      return 32'h0002_8BE6;
            13:      return 32'h0001_45F3;
            14:      return 32'h0000_A2FA;
            15:      return 32'h0000_517D;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/cordic.sv
// Pipelined rotation-mode CORDIC: quarter-turn pre-rotation, ITER micro-rotations from 2^-1, rounded output.
module cordic
    import dds_pkg::*;
#(
    parameter int unsigned PW   = 16,
    parameter int unsigned VW   = 16,
    parameter int unsigned ITER = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] phase,
    input  logic [VW-1:0] x_inp,
    output logic [VW:0]   x_out,
    output logic [VW:0]   y_out
);

    localparam int unsigned GB = 3;
    localparam int unsigned IW = VW + GB + 2;
    localparam logic [PW-1:0] EIGHTH = {3'b001, {(PW-3){1'b0}}};
    localparam logic signed [IW-1:0] HALF = {{(IW-GB){1'b0}}, 1'b1, {(GB-1){1'b0}}};

    function automatic logic [PW-1:0] at_step(input int unsigned s);
        logic [31:0] a;
        a = atan_turns32(s);
        return PW'((a + (32'd1 << (31 - PW))) >> (32 - PW));
    endfunction

    logic signed [IW-1:0] xs [ITER+1];
    logic signed [IW-1:0] ys [ITER+1];
    logic signed [PW-1:0] zs [ITER+1];
    logic [PW-1:0]        ph_rnd;
    logic [1:0]           quad;
    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] x_rnd;
    logic signed [IW-1:0] y_rnd;

    // nearest quarter turn leaves a residual within +/-45 degrees
    assign ph_rnd = phase + EIGHTH;
    assign quad   = ph_rnd[PW-1 -: 2];
    assign x_ext  = $signed({{(IW-VW-GB){x_inp[VW-1]}}, x_inp, {GB{1'b0}}});
    assign x_rnd  = xs[ITER] + HALF;
    assign y_rnd  = ys[ITER] + HALF;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ITER; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                zs[i] <= '0;
            end
            x_out <= '0;
            y_out <= '0;
        end else begin
            case (quad)
                2'd0:    begin xs[0] <= x_ext;  ys[0] <= '0;     end
                2'd1:    begin xs[0] <= '0;     ys[0] <= x_ext;  end
                2'd2:    begin xs[0] <= -x_ext; ys[0] <= '0;     end
                default: begin xs[0] <= '0;     ys[0] <= -x_ext; end
            endcase
            zs[0] <= $signed(phase - {quad, {(PW-2){1'b0}}});
            for (int i = 0; i < ITER; i++) begin
                if (!zs[i][PW-1]) begin
                    xs[i+1] <= xs[i] - (ys[i] >>> (i + 1));
                    ys[i+1] <= ys[i] + (xs[i] >>> (i + 1));
                    zs[i+1] <= zs[i] - $signed(at_step(i + 1));
                end else begin
                    xs[i+1] <= xs[i] + (ys[i] >>> (i + 1));
                    ys[i+1] <= ys[i] - (xs[i] >>> (i + 1));
                    zs[i+1] <= zs[i] + $signed(at_step(i + 1));
                end
            end
            x_out <= x_rnd[GB +: VW+1];
            y_out <= y_rnd[GB +: VW+1];
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Two-channel DDS: phase accumulators time-share one CORDIC, with tag-tracked outputs and slot-aligned config commit.
module cordic_sched
    import dds_pkg::*;
#(
    parameter int unsigned PW   = 16,
    parameter int unsigned VW   = 16,
    parameter int unsigned ITER = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic          cfg_ch,
    input  logic          cfg_en,
    input  logic          cfg_ph_clr,
    input  logic [PW-1:0] cfg_ftw,
    input  logic [VW-1:0] cfg_amp,
    output logic [VW:0]   ch0_cos,
    output logic [VW:0]   ch0_sin,
    output logic          ch0_valid,
    output logic [VW:0]   ch1_cos,
    output logic [VW:0]   ch1_sin,
    output logic          ch1_valid
);

    localparam int unsigned LAT_C = cordic_lat(ITER);

    typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;

    cfg_state_t     state, state_nxt;
    logic           slot;
    logic [PW-1:0]  acc [NCH];
    logic [PW-1:0]  ftw [NCH];
    logic [VW-1:0]  amp [NCH];
    logic [NCH-1:0] en;
    ch_t            sh_ch;
    logic           sh_en, sh_clr;
    logic [PW-1:0]  sh_ftw;
    logic [VW-1:0]  sh_amp;
    tag_t           tags [LAT_C];
    tag_t           tag_out;
    logic           issue_c, commit_c, hs_c;
    logic [PW-1:0]  cd_phase;
    logic [VW-1:0]  cd_x;
    logic [VW:0]    cd_xo, cd_yo;

    assign cd_phase = acc[slot];
    assign cd_x     = amp[slot];
    assign tag_out  = tags[LAT_C-1];

    // config pending FSM; commit waits for the target channel's slot while running
    always_comb begin
        state_nxt = state;
        hs_c      = cfg_valid & cfg_ready;
        commit_c  = 1'b0;
        issue_c   = run & en[slot];
        case (state)
            CFG_IDLE: if (hs_c) state_nxt = CFG_PEND;
            CFG_PEND: begin
                commit_c = ~run | (slot == sh_ch);
                if (commit_c) state_nxt = CFG_IDLE;
            end
            default:  state_nxt = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CFG_IDLE;
            cfg_ready <= 1'b1;
            slot      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt == CFG_IDLE);
            slot      <= slot ^ run;
        end
    end

    // the commit-cycle issue still uses the old ftw/amp; phase clear wins over the add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
                ftw[c] <= '0;
                amp[c] <= VW'(AMP_DEFAULT);
            end
            en     <= '0;
            sh_ch  <= 1'b0;
            sh_en  <= 1'b0;
            sh_clr <= 1'b0;
            sh_ftw <= '0;
            sh_amp <= '0;
        end else begin
            if (hs_c) begin
                sh_ch  <= cfg_ch;
                sh_en  <= cfg_en;
                sh_clr <= cfg_ph_clr;
                sh_ftw <= cfg_ftw;
                sh_amp <= cfg_amp;
            end
            for (int c = 0; c < NCH; c++) begin
                if (commit_c && sh_ch == 1'(c)) begin
                    ftw[c] <= sh_ftw;
                    amp[c] <= sh_amp;
                    en[c]  <= sh_en;
                end
                if (commit_c && sh_ch == 1'(c) && sh_clr) begin
                    acc[c] <= '0;
                end else if (issue_c && slot == 1'(c)) begin
                    acc[c] <= acc[c] + ftw[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT_C; i++) tags[i] <= '0;
        end else begin
            tags[0] <= tag_t'{valid: issue_c, ch: slot};
            for (int i = 1; i < LAT_C; i++) tags[i] <= tags[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch0_valid <= 1'b0;
            ch1_valid <= 1'b0;
            ch0_cos   <= '0;
            ch0_sin   <= '0;
            ch1_cos   <= '0;
            ch1_sin   <= '0;
        end else begin
            ch0_valid <= tag_out.valid & (tag_out.ch == 1'b0);
            ch1_valid <= tag_out.valid & (tag_out.ch == 1'b1);
            if (tag_out.valid && tag_out.ch == 1'b0) begin
                ch0_cos <= cd_xo;
                ch0_sin <= cd_yo;
            end
            if (tag_out.valid && tag_out.ch == 1'b1) begin
                ch1_cos <= cd_xo;
                ch1_sin <= cd_yo;
            end
        end
    end

    cordic #(
        .PW   (PW),
        .VW   (VW),
        .ITER (ITER)
    ) u_cordic (
        .clk   (clk),
        .rst   (1'b0),
        .phase (cd_phase),
        .x_inp (cd_x),
        .x_out (cd_xo),
        .y_out (cd_yo)
    );

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched: transaction-level DDS model plus directed literal checks.
module tb_cordic_sched;

    localparam int    TOL  = 64;
    localparam int    LATS = 13;
    localparam real   GAIN = 1.164435;
    localparam real   PI   = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_ch = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_ph_clr = 1'b0;
    logic [15:0] cfg_ftw = '0;
    logic [15:0] cfg_amp = '0;
    logic [16:0] ch0_cos, ch0_sin, ch1_cos, ch1_sin;
    logic        ch0_valid, ch1_valid;

    int vectors = 0;
    int errs = 0;

    cordic_sched dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_ph_clr(cfg_ph_clr), .cfg_ftw(cfg_ftw), .cfg_amp(cfg_amp),
        .ch0_cos(ch0_cos), .ch0_sin(ch0_sin), .ch0_valid(ch0_valid),
        .ch1_cos(ch1_cos), .ch1_sin(ch1_sin), .ch1_valid(ch1_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model and per-cycle compare ----------------
    typedef struct {
        int due;
        int ch;
        int ph;
        int amp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   m_slot = 0;
    int   m_acc[2] = '{0, 0};
    int   m_ftw[2] = '{0, 0};
    int   m_amp[2] = '{28141, 28141};
    int   m_en[2]  = '{0, 0};
    int   m_ready = 1;
    int   m_pend = 0;
    int   sh_ch, sh_en, sh_clr, sh_ftw, sh_amp;
    int   held_c[2] = '{0, 0};
    int   held_s[2] = '{0, 0};

    function automatic int ideal(input int a, input int ph, input bit want_sin);
        real ang, v;
        ang = 2.0 * PI * real'(ph) / 65536.0;
        v = real'(a) * GAIN * (want_sin ? $sin(ang) : $cos(ang));
        return int'(v);
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    always @(negedge clk) begin : chk
        int  act_v[2], act_c[2], act_s[2];
        bit  ev[2];
        int  issue, commit;
        exp_t e;
        act_v[0] = int'(ch0_valid);
        act_v[1] = int'(ch1_valid);
        act_c[0] = int'($signed(ch0_cos));
        act_s[0] = int'($signed(ch0_sin));
        act_c[1] = int'($signed(ch1_cos));
        act_s[1] = int'($signed(ch1_sin));
        if (!rst_n) begin
            vectors++;
            if (act_v[0] != 0 || act_v[1] != 0 || act_c[0] != 0 || act_s[0] != 0 ||
                act_c[1] != 0 || act_s[1] != 0 || cfg_ready !== 1'b1) begin
                errs++;
                $display("FAIL reset_state cyc=%0d: v=%0d/%0d c0=%0d s0=%0d c1=%0d s1=%0d rdy=%b, need all 0 and rdy=1",
                         cyc, act_v[0], act_v[1], act_c[0], act_s[0], act_c[1], act_s[1], cfg_ready);
            end
            q.delete();
            m_slot = 0; m_ready = 1; m_pend = 0;
            for (int c = 0; c < 2; c++) begin
                m_acc[c] = 0; m_ftw[c] = 0; m_amp[c] = 28141; m_en[c] = 0;
                held_c[c] = 0; held_s[c] = 0;
            end
        end else begin
            ev[0] = 1'b0;
            ev[1] = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                ev[e.ch] = 1'b1;
                held_c[e.ch] = ideal(e.amp, e.ph, 1'b0);
                held_s[e.ch] = ideal(e.amp, e.ph, 1'b1);
            end
            for (int c = 0; c < 2; c++) begin
                vectors++;
                if (act_v[c] != int'(ev[c])) begin
                    errs++;
                    $display("FAIL ch%0d_valid cyc=%0d: got %0d want %0d", c, cyc, act_v[c], ev[c]);
                end
                vectors++;
                if (absd(act_c[c], held_c[c]) > TOL || absd(act_s[c], held_s[c]) > TOL) begin
                    errs++;
                    $display("FAIL ch%0d_data cyc=%0d: got cos=%0d sin=%0d want cos=%0d sin=%0d (+/-%0d)",
                             c, cyc, act_c[c], act_s[c], held_c[c], held_s[c], TOL);
                end
            end
            vectors++;
            if (cfg_ready !== 1'(m_ready)) begin
                errs++;
                $display("FAIL cfg_ready cyc=%0d: got %b want %0d", cyc, cfg_ready, m_ready);
            end
            // advance the model over this cycle
            issue  = (run && m_en[m_slot] != 0) ? 1 : 0;
            commit = (m_pend != 0 && (!run || m_slot == sh_ch)) ? 1 : 0;
            if (issue != 0) begin
                q.push_back('{due: cyc + LATS, ch: m_slot, ph: m_acc[m_slot], amp: m_amp[m_slot]});
                m_acc[m_slot] = (m_acc[m_slot] + m_ftw[m_slot]) % 65536;
            end
            if (commit != 0) begin
                m_ftw[sh_ch] = sh_ftw;
                m_amp[sh_ch] = sh_amp;
                m_en[sh_ch]  = sh_en;
                if (sh_clr != 0) m_acc[sh_ch] = 0;
                m_pend = 0;
                m_ready = 1;
            end else if (cfg_valid && m_ready != 0) begin
                sh_ch = int'(cfg_ch); sh_en = int'(cfg_en); sh_clr = int'(cfg_ph_clr);
                sh_ftw = int'(cfg_ftw); sh_amp = int'($signed(cfg_amp));
                m_pend = 1;
                m_ready = 0;
            end
            if (run) m_slot = 1 - m_slot;
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    int cap_c[8];
    int cap_s[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_near(input string name, input int act, input int want);
        vectors++;
        if (absd(act, want) > TOL) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (+/-%0d)", name, act, want, TOL);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            errs++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_cfg(input bit ch, input bit en, input bit clr, input int ftw, input int amp,
                          output int low);
        bit ok;
        cfg_ch = ch; cfg_en = en; cfg_ph_clr = clr;
        cfg_ftw = 16'(ftw); cfg_amp = 16'(amp);
        cfg_valid = 1'b1;
        ok = 1'b0;
        low = -1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1'b1;
        end
        tick();
        cfg_valid = 1'b0;
        cfg_ftw = 16'hDEAD; cfg_amp = 16'h0000; cfg_ch = ~ch; cfg_ph_clr = 1'b0;
        if (!ok) begin
            vectors++; errs++;
            $display("FAIL cfg_handshake: got no cfg_ready within 30 cycles, want ready");
        end else begin
            low = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (cfg_ready) break;
                low++;
            end
        end
    endtask

    task automatic capture(input int ch, input int n);
        int got;
        got = 0;
        for (int i = 0; i < 200 && got < n; i++) begin
            @(negedge clk);
            if ((ch == 0 && ch0_valid) || (ch == 1 && ch1_valid)) begin
                cap_c[got] = (ch == 0) ? int'($signed(ch0_cos)) : int'($signed(ch1_cos));
                cap_s[got] = (ch == 0) ? int'($signed(ch0_sin)) : int'($signed(ch1_sin));
                got++;
            end
        end
        check_range("capture_count", got, n, n);
    endtask

    task automatic meas_lat(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ch0_valid) begin
                n = i;
                break;
            end
        end
        check_range(name, n - 1, LATS, LATS);
        if (n > 0) begin
            check_near({name, "_cos"}, int'($signed(ch0_cos)), 32767);
            check_near({name, "_sin"}, int'($signed(ch0_sin)), 0);
        end
    endtask

    initial begin : stim
        int low, n0, n1;
        int w4c[4] = '{32767, 0, -32767, 0};
        int w4s[4] = '{0, 32767, 0, -32767};
        int w3c[3] = '{32767, 23170, 0};
        int w3s[3] = '{0, 23170, 32767};
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // single channel, ftw=0: latency and DC output
        do_cfg(1'b0, 1'b1, 1'b1, 0, 16'h6DED, low);
        check_range("cfg_ready_low_idle", low, 1, 1);
        tick();
        run = 1'b1;
        meas_lat("first_strobe_latency");
        repeat (20) tick();

        // quarter-turn steps
        run = 1'b0;
        repeat (20) tick();
        do_cfg(1'b0, 1'b1, 1'b1, 16'h4000, 16'h6DED, low);
        tick();
        run = 1'b1;
        capture(0, 4);
        for (int i = 0; i < 4; i++) begin
            check_near($sformatf("quarter_cos[%0d]", i), cap_c[i], w4c[i]);
            check_near($sformatf("quarter_sin[%0d]", i), cap_s[i], w4s[i]);
        end

        // two interleaved channels
        run = 1'b0;
        repeat (20) tick();
        do_cfg(1'b0, 1'b1, 1'b1, 16'h1000, 16'h6DED, low);
        do_cfg(1'b1, 1'b1, 1'b1, 16'h2000, 16'h6DED, low);
        tick();
        run = 1'b1;
        capture(1, 3);
        for (int i = 0; i < 3; i++) begin
            check_near($sformatf("ch1_cos[%0d]", i), cap_c[i], w3c[i]);
            check_near($sformatf("ch1_sin[%0d]", i), cap_s[i], w3s[i]);
        end
        repeat (40) tick();

        // live reconfig of ch1 with phase clear
        do_cfg(1'b1, 1'b1, 1'b1, 16'h2000, 16'h6DED, low);
        check_range("cfg_ready_low_running", low, 1, 2);
        repeat (40) tick();

        // run falls: only in-flight samples strobe
        run = 1'b0;
        @(negedge clk);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ch0_valid) n0++;
            if (ch1_valid) n1++;
        end
        check_range("drain_ch0", n0, 6, 6);
        check_range("drain_ch1", n1, 6, 6);

        // reset mid-stream
        tick();
        run = 1'b1;
        repeat (17) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        run = 1'b0;
        tick();
        do_cfg(1'b0, 1'b1, 1'b0, 0, 16'h6DED, low);
        tick();
        run = 1'b1;
        meas_lat("post_reset_latency");
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
